// File: rtl/jt900h_pkg.sv
// Shared definitions for the TLCS-900H divider: FSM encoding and width constants.
package jt900h_pkg;

  typedef enum logic [2:0] {StIdle, StPrep, StIter, StFix, StDone} div_st_e;

  localparam int unsigned DIV8_W  = 8;
  localparam int unsigned DIV16_W = 16;

  // Quotient returned on divide-by-zero or early overflow
  localparam logic [15:0] DIV0_QUO = 16'hFFFF;

endpackage

// File: rtl/jt900h_div_if.sv
// Launch/result bundle between the instruction sequencer and the DIV/DIVS unit.
interface jt900h_div_if;
  logic        start;
  logic        ws;
  logic        sgn;
  logic [31:0] op0;
  logic [15:0] op1;
  logic        busy;
  logic        done;
  logic        v;
  logic [31:0] rslt;

  modport master (output start, ws, sgn, op0, op1, input busy, done, v, rslt);
  modport slave  (input start, ws, sgn, op0, op1, output busy, done, v, rslt);
endinterface

// File: rtl/jt900h_div_step.sv
// One radix-2 restoring division step: trial subtract and shift.
module jt900h_div_step #(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] rem,
  input  logic [N-1:0] dvs,
  input  logic         in_bit,
  output logic [N-1:0] rem_nx,
  output logic         q_bit
);
  logic [N:0]   trial;
  logic [N-1:0] diff;

  always_comb begin
    trial  = {rem, in_bit};
    // rem < dvs holds on entry, so a kept difference always fits in N bits
    diff   = trial[N-1:0] - dvs;
    q_bit  = trial >= {1'b0, dvs};
    rem_nx = q_bit ? diff : trial[N-1:0];
  end
endmodule

// File: rtl/jt900h_div.sv
// Multi-cycle DIV/DIVS sequencer (16/8 and 32/16). Define JT900H_DIVS_EN to build
// the signed path; otherwise sgn is ignored and every division is unsigned.
module jt900h_div
  import jt900h_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  jt900h_div_if.slave     bus
);
  div_st_e     st;
  logic        ws_l;
  logic [31:0] op0_l;
  logic [15:0] op1_l;
  logic [15:0] rem, lo;
  logic [4:0]  cnt;
  logic        busy_q, done_q, v_q;
  logic [31:0] rslt_q;
`ifdef JT900H_DIVS_EN
  logic        sgn_l;
  logic        neg;
  logic [15:0] half;
`endif

  logic        a_neg, b_neg, in_bit, q_bit, ovf;
  logic [15:0] a_lo_neg, b_mag, hi_mag, rem_nx, q_w, q_fix, r_fix;
  logic [7:0]  b_lo_neg;
  logic [31:0] a_mag, rslt_nx;

  jt900h_div_step #(
    .N (DIV16_W)
  ) u_step (
    .rem    (rem),
    .dvs    (b_mag),
    .in_bit (in_bit),
    .rem_nx (rem_nx),
    .q_bit  (q_bit)
  );

  always_comb begin
`ifdef JT900H_DIVS_EN
    a_neg = sgn_l & (ws_l ? op0_l[31] : op0_l[15]);
    b_neg = sgn_l & (ws_l ? op1_l[15] : op1_l[7]);
`else
    a_neg = 1'b0;
    b_neg = 1'b0;
`endif
    a_lo_neg = -op0_l[15:0];
    b_lo_neg = -op1_l[7:0];
    a_mag    = ws_l ? (a_neg ? -op0_l : op0_l) : {16'h0, a_neg ? a_lo_neg : op0_l[15:0]};
    b_mag    = ws_l ? (b_neg ? -op1_l : op1_l) : {8'h0, b_neg ? b_lo_neg : op1_l[7:0]};
    hi_mag   = ws_l ? a_mag[31:16] : {8'h0, a_mag[15:8]};
    in_bit   = ws_l ? lo[15] : lo[7];
    q_w      = ws_l ? lo : {8'h0, lo[7:0]};
    q_fix    = q_w;
    r_fix    = rem;
    ovf      = 1'b0;
`ifdef JT900H_DIVS_EN
    neg  = a_neg ^ b_neg;
    half = ws_l ? 16'h8000 : 16'h0080;
    // v already set means an early exit: its fixed result is not sign-corrected
    if (!v_q) begin
      if (neg)   q_fix = -q_w;
      if (a_neg) r_fix = -rem;
      ovf = neg ? (q_w > half) : (q_w >= half);
    end
`endif
    rslt_nx = ws_l ? {r_fix, q_fix} : {16'h0, r_fix[7:0], q_fix[7:0]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st     <= StIdle;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      v_q    <= 1'b0;
      rslt_q <= '0;
      cnt    <= '0;
      ws_l   <= 1'b0;
      op0_l  <= '0;
      op1_l  <= '0;
      rem    <= '0;
      lo     <= '0;
`ifdef JT900H_DIVS_EN
      sgn_l  <= 1'b0;
`endif
    end else if (cen) begin
      unique case (st)
        StIdle: if (bus.start) begin
          ws_l   <= bus.ws;
          op0_l  <= bus.op0;
          op1_l  <= bus.op1;
`ifdef JT900H_DIVS_EN
          sgn_l  <= bus.sgn;
`endif
          busy_q <= 1'b1;
          v_q    <= 1'b0;
          st     <= StPrep;
        end
        StPrep: begin
          // Quotient would not fit in N bits: return the fixed overflow pattern
          if (b_mag == 16'h0 || hi_mag >= b_mag) begin
            v_q <= 1'b1;
            lo  <= DIV0_QUO;
            rem <= ws_l ? op0_l[15:0] : {8'h0, op0_l[7:0]};
            st  <= StFix;
          end else begin
            rem <= hi_mag;
            lo  <= a_mag[15:0];
            cnt <= ws_l ? 5'(DIV16_W) : 5'(DIV8_W);
            st  <= StIter;
          end
        end
        StIter: begin
          rem <= rem_nx;
          lo  <= {lo[14:0], q_bit};
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) st <= StFix;
        end
        StFix: begin
          rslt_q <= rslt_nx;
          v_q    <= v_q | ovf;
          done_q <= 1'b1;
          st     <= StDone;
        end
        StDone: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          st     <= StIdle;
        end
        default: st <= StIdle;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.v    = v_q;
  assign bus.rslt = rslt_q;
endmodule

// File: tb/tb_jt900h_div.sv
// Scoreboard bench for jt900h_div: arithmetic reference model, random and directed operands.
module tb_jt900h_div;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cen = 1'b1;

  jt900h_div_if bus ();

  jt900h_div dut (
    .clk (clk),
    .rst (rst),
    .cen (cen),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rslt;
    logic        v;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  int   last_done = -1;
  int   n_done = 0;
  int   n_issued = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input bit ws, input bit sgn, input logic [31:0] a_in,
                                 input logic [15:0] b_in);
    exp_t   e;
    int     n;
    longint mask, a0, a, b, q, r;
    bit     sg, aneg, bneg;
    n    = ws ? 16 : 8;
    mask = (longint'(1) << n) - 1;
    a0   = ws ? longint'(a_in) : longint'(a_in[15:0]);
    b    = ws ? longint'(b_in) : longint'(b_in[7:0]);
    a    = a0;
    sg   = sgn;
`ifndef JT900H_DIVS_EN
    sg   = 1'b0;
`endif
    aneg = sg && a[2*n-1];
    bneg = sg && b[n-1];
    if (aneg) a = (longint'(1) << (2*n)) - a;
    if (bneg) b = (longint'(1) << n) - b;
    e.acc = 0;
    if (b == 0 || (a >> n) >= b) begin
      e.v   = 1'b1;
      q     = mask;
      r     = a0 & mask;
      e.lat = 3;
    end else begin
      q     = a / b;
      r     = a % b;
      e.lat = n + 3;
      e.v   = 1'b0;
      if (sg) begin
        if (aneg ^ bneg) begin
          e.v = q > (longint'(1) << (n-1));
          q   = -q;
        end else begin
          e.v = q > (longint'(1) << (n-1)) - 1;
        end
        if (aneg) r = -r;
      end
    end
    e.rslt = 32'(((r & mask) << n) | (q & mask));
    return e;
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst && cen) edge_cnt++;
  end

  initial forever begin
    @(negedge clk);
    if (rst && bus.done && edge_cnt != last_done) begin
      last_done = edge_cnt;
      n_done++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1, expected no pending result");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rslt", bus.rslt, e.rslt);
        chk("v", bus.v, e.v);
        chk("latency", edge_cnt - e.acc + 1, e.lat);
      end
    end
  end

  task automatic run_op(input bit ws, input bit sgn, input logic [31:0] a,
                        input logic [15:0] b, input bit cen_rand, input bit hold,
                        input int abort_at);
    int   guard = 0;
    bit   acc = 1'b0;
    exp_t e;
    while (bus.busy && guard < 100) begin
      bus.start = 1'b0;
      cen = 1'b1;
      @(negedge clk);
      guard++;
    end
    while (!acc && guard < 200) begin
      bus.start = 1'b1;
      bus.ws    = ws;
      bus.sgn   = sgn;
      bus.op0   = a;
      bus.op1   = b;
      cen       = cen_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cen && !bus.busy) begin
        acc   = 1'b1;
        e     = model(ws, sgn, a, b);
        e.acc = edge_cnt + 1;
        sb_q.push_back(e);
        if (abort_at == 0) n_issued++;
      end
      @(negedge clk);
      guard++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got busy=%0b, expected start accepted", bus.busy);
    end
    guard = 0;
    while (acc && !bus.done && guard < 300) begin
      if (abort_at > 0 && guard == abort_at) begin
        rst = 1'b0;
        sb_q.delete();
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_rslt", bus.rslt, 0);
        chk("abort_done", bus.done, 0);
        @(negedge clk);
        rst = 1'b1;
        break;
      end
      bus.start = hold;
      bus.ws    = 1'($urandom_range(0, 1));
      bus.sgn   = 1'($urandom_range(0, 1));
      bus.op0   = $urandom;
      bus.op1   = 16'($urandom);
      cen       = cen_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      guard++;
    end
    if (acc && abort_at == 0 && !bus.done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got done=0, expected done within 300 cycles");
    end
    bus.start = 1'b0;
    cen       = 1'b1;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.ws    = 1'b0;
    bus.sgn   = 1'b0;
    bus.op0   = '0;
    bus.op1   = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_v", bus.v, 0);
    chk("reset_rslt", bus.rslt, 0);
    rst = 1'b1;
    @(negedge clk);

    run_op(1'b0, 1'b0, 32'h0000_0064, 16'h0007, 1'b0, 1'b0, 0);
    run_op(1'b1, 1'b0, 32'h0001_0000, 16'h0003, 1'b0, 1'b0, 0);
    run_op(1'b0, 1'b0, 32'h0000_1234, 16'h0000, 1'b0, 1'b0, 0);
    run_op(1'b0, 1'b0, 32'h0000_0800, 16'h0008, 1'b0, 1'b0, 0);
    run_op(1'b0, 1'b1, 32'h0000_FF9C, 16'h0007, 1'b0, 1'b0, 0);
    run_op(1'b1, 1'b1, 32'hFFFF_8000, 16'hFFFF, 1'b0, 1'b0, 0);
    run_op(1'b1, 1'b0, 32'h1234_5678, 16'h9ABC, 1'b1, 1'b0, 0);
    run_op(1'b0, 1'b0, 32'h0000_00FF, 16'h0010, 1'b0, 1'b1, 0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [15:0] b;
      bit          ws;
      ws = 1'($urandom_range(0, 1));
      a  = $urandom;
      b  = 16'($urandom);
      if ($urandom_range(0, 1) == 1) a = ws ? (a >> $urandom_range(1, 16)) : (a & 32'h0FFF);
      if ($urandom_range(0, 15) == 0) b = 16'h0;
      run_op(ws, 1'($urandom_range(0, 1)), a, b, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 0);
    end

    run_op(1'b1, 1'b0, 32'h1234_5678, 16'h9ABC, 1'b0, 1'b0, 6);
    repeat (40) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    chk("done_count", n_done, n_issued);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/jt900h_div.md
Name: jt900h_div

Overview:
- Multi-cycle DIV/DIVS sequencer for the TLCS-900H core.
- Takes a dividend and a divisor, then runs one radix-2 restoring-subtract step per enabled clock.
- Returns the quotient in the low half of the result and the remainder in the high half, plus the overflow flag (V).
- Sits beside the main ALU. The instruction sequencer launches it with `start` and stalls on `busy`.

Parameters:
- None. Widths are fixed by the instruction set: 16/8 division or 32/16 division.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- cen  in  1  clock enable; all state advances only when high
- start  in  1  launch request; sampled when cen=1 and busy=0
- ws  in  1  0: 16-bit dividend / 8-bit divisor; 1: 32-bit dividend / 16-bit divisor
- sgn  in  1  1: signed division (DIVS)
- op0  in  32  dividend; only [15:0] is used when ws=0
- op1  in  16  divisor; only [7:0] is used when ws=0
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one cen-cycle pulse when the result is valid
- v  out  1  overflow or divide-by-zero
- rslt  out  32  result: {remainder, quotient}. ws=0 uses [15:0] = {rem8, quo8} and [31:16] reads 0.

Behaviour:
- Reset (asynchronous, active low) forces:
  - state=IDLE
  - busy=0, done=0, v=0, rslt=0
  - iteration counter = 0
- Reset mid-operation aborts the division. No done pulse follows.
- Width N = 8 (ws=0) or 16 (ws=1).
- ws, sgn, op0 and op1 are latched on acceptance. Later input changes are ignored.
- FSM states: IDLE, PREP, ITER, FIX, DONE. All transitions are qualified by cen; cen=0 freezes everything, including done.
- IDLE:
  - On start, latch operands, busy<=1, go to PREP.
  - start while busy is ignored and not queued.
- PREP:
  - Take magnitudes when sgn=1; operands pass unchanged when sgn=0.
  - Divisor==0: set v<=1, quotient<=all ones (N bits), remainder<=dividend[N-1:0], go to FIX.
  - Unsigned, dividend high half >= divisor: same early exit as divisor==0.
  - Otherwise load the partial remainder with the dividend high half, set counter=N, go to ITER.
- ITER, each cycle:
  - Trial-subtract the divisor from {partial remainder, next dividend bit}.
  - If non-negative, keep the difference and shift in quotient bit 1; otherwise shift in 0.
  - Decrement the counter; when it reaches 1, go to FIX.
- FIX:
  - For sgn=1, negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
  - Signed overflow: quotient magnitude > 2^(N-1)-1 for a positive result, or > 2^(N-1) for a negative one. It sets v=1, and rslt keeps the truncated value.
  - Write rslt, then go to DONE.
- DONE:
  - done=1 for one cen cycle, busy<=0, return to IDLE.
  - rslt and v hold until the next accepted start. v clears on acceptance.
- Latency, counted in cen cycles from the accepting edge to the done cycle:
  - normal: 2+N+1 (11 for ws=0, 19 for ws=1)
  - early exit: 3
- start during DONE is ignored. A new start is accepted in IDLE on the following cycle.

Optional Feature:
- JT900H_DIVS_EN defined: signed path (magnitudes, sign fix and signed overflow) is built.
- JT900H_DIVS_EN undefined: sgn is ignored, all divisions are unsigned, and the FIX stage only writes rslt. Latency is unchanged.

Decomposition:
- Shared package (jt900h_pkg): FSM state encoding, width constants (DIV8_W=8, DIV16_W=16), and the div-by-zero quotient constant.
- One natural sub-module: jt900h_div_step. It is combinational: a trial subtract plus shift of one radix-2 step, parameterised on N. The parent holds the FSM, counter and registers.

Test Plan:
- Unsigned 16/8: op0=0x0064, op1=0x07, ws=0, sgn=0 -> rslt=0x00000E02? No: rslt[15:0]=0x020E (rem 2, quo 14), v=0, done on the 11th cen cycle after start.
- Unsigned 32/16: op0=0x00010000, op1=0x0003, ws=1 -> rslt=0x00015555, v=0, done on the 19th cen cycle.
- Divide by zero: op0=0x1234, op1=0x00, ws=0 -> v=1, rslt[7:0]=0xFF, rslt[15:8]=0x34, done on the 3rd cycle.
- Unsigned overflow: op0=0x0800, op1=0x08 -> v=1, early exit, done on the 3rd cycle.
- Signed (with JT900H_DIVS_EN): op0=0xFF9C, op1=0x07, sgn=1, ws=0 -> rslt[15:0]=0xFEF2, v=0. Without the macro, the same stimulus gives the unsigned result 0x9C? rslt computed on 0xFF9C/7 -> early overflow (0xFF>=7), v=1.
- Control: cen toggled 50% mid-ITER -> latency stretches only by the cen=0 cycles. rst pulsed low mid-ITER -> busy=0, rslt=0 immediately and no done pulse. start held high through busy -> exactly one done pulse.
